// File: rtl/dcache_mem_responder_pkg.sv
// Shared definitions for the data-cache backing memory responder.
//   LINE_W           : bits per cache line / transfer unit
//   LINE_OFFSET_BITS : byte-offset bits below the line index
//   DEFAULT_LATENCY  : default access latency in cycles
//   state_e          : responder FSM state encoding
package dcache_mem_responder_pkg;

  localparam int LINE_W           = 256;
  localparam int LINE_OFFSET_BITS = 5;
  localparam int DEFAULT_LATENCY  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/dcache_mem_array.sv
// Single-port line storage: synchronous write, combinational read.
// Contents are deliberately not reset.
//   clk_i   : clock
//   we_i    : write enable, commits wdata_i at the rising edge
//   idx_i   : line index (shared by read and write)
//   wdata_i : write line
//   rdata_o : line currently stored at idx_i
module dcache_mem_array #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 1024,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dcache_mem_responder.sv
// Backing data memory answering dcache line fills and write-backs.
// One request at a time; ack_o pulses exactly LATENCY cycles after the
// edge that accepted the request.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset
//   req_i   : request valid, sampled only in IDLE
//   write_i : 1 = write-back, 0 = line fill
//   addr_i  : byte address (offset bits ignored, upper bits alias)
//   data_i  : write line
//   ack_o   : one-cycle completion pulse
//   data_o  : last read line, valid with ack_o on a read
//   busy_o  : request in flight
//
// state | meaning
// IDLE  | waiting for req_i
// BUSY  | counting down the access latency
// ACK   | final cycle: memory write / read capture happens at its exit edge
module dcache_mem_responder
  import dcache_mem_responder_pkg::*;
#(
  parameter int LINE_WIDTH = LINE_W,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = DEFAULT_LATENCY
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  write_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LINE_WIDTH-1:0] data_i,
  output logic                  ack_o,
  output logic [LINE_WIDTH-1:0] data_o,
  output logic                  busy_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int IDX_LO = LINE_OFFSET_BITS;
  localparam int IDX_HI = IDX_LO + IDX_W - 1;
  // Counter only ever holds LATENCY-1 down to 0.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ack_q;
  logic                   busy_q;
  logic [LINE_WIDTH-1:0]  data_q;
  logic                   write_q;
  logic [IDX_W-1:0]       idx_q;
  logic [LINE_WIDTH-1:0]  wdata_q;

  logic                   mem_we;
  logic [LINE_WIDTH-1:0]  mem_rdata;

  logic                   unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[ADDR_WIDTH-1:IDX_HI+1], addr_i[IDX_LO-1:0]};

  // The commit happens on the edge that leaves ACK, so an abort by reset
  // before that edge never touches the array.
  assign mem_we = (state_q == ST_ACK) && write_q;

  dcache_mem_array #(
    .WIDTH (LINE_WIDTH),
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            write_q <= write_i;
            idx_q   <= addr_i[IDX_HI:IDX_LO];
            wdata_q <= data_i;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            state_q <= (LATENCY == 1) ? ST_ACK : ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Entering ACK as the counter hits zero puts the registered
          // ack exactly LATENCY edges after acceptance.
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= ST_ACK;
        end
        ST_ACK: begin
          ack_q   <= 1'b1;
          busy_q  <= 1'b0;
          if (!write_q) data_q <= mem_rdata;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack_o  = ack_q;
  assign busy_o = busy_q;
  assign data_o = data_q;

endmodule
